bullets_pool: RTL and testbench

Manages a pool of three player bullets for the VGA game: accepts fire requests, spawns bullets above the player, moves them upward once per frame, retires them on collision or when they leave the screen, and renders them. It sits directly upstream of the objects mux. Each bullet has its own drawing-request bit. All bullets share one RGB value. Both outputs are registered so they line up with the other object drawers.

---
 rtl/bullets_pkg.sv | 19 +
 rtl/bullet_slot.sv | 68 ++++++
 rtl/bullets_pool.sv | 149 ++++++++++++++
 tb/tb_bullets_pool.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullets_pkg.sv
// rtl/bullets_pkg.sv - shared types, sizes and helpers for the player bullet pool
package bullets_pkg;

  localparam int NUM_BULLETS = 3;
  localparam int COORD_W     = 11;

  // One bullet slot: active means FLYING, (x, y) is the top-left corner.
  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

  // Number of set bits in a slot vector (0..3).
  function automatic logic [1:0] popcount3(input logic [NUM_BULLETS-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// rtl/bullet_slot.sv - one bullet slot: IDLE/FLYING state, per-frame move, kill and pixel hit test
module bullet_slot
  import bullets_pkg::*;
#(
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8,
  parameter int SPEED    = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_of_frame,
  input  logic               spawn,
  input  logic               kill,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               active,
  output logic               active_next,
  output logic               hit
);

  slot_t slot_q, slot_d;

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  // State register: asynchronous reset drops the bullet immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Next state: kill beats everything, then spawn, then the upward move.
  always_comb begin
    slot_d = slot_q;
    if (kill) begin
      slot_d.active = 1'b0;
    end else if (start_of_frame) begin
      if (spawn) begin
        slot_d.active = 1'b1;
        slot_d.x      = spawn_x;
        slot_d.y      = spawn_y;
      end else if (slot_q.active) begin
        if (slot_q.y >= COORD_W'(SPEED)) begin
          slot_d.y = slot_q.y - COORD_W'(SPEED);
        end else begin
          slot_d.active = 1'b0;
        end
      end
    end
  end

  // Outputs: hit test with one extra bit so x+W / y+H cannot wrap.
  always_comb begin
    x_end       = {1'b0, slot_q.x} + (COORD_W+1)'(BULLET_W);
    y_end       = {1'b0, slot_q.y} + (COORD_W+1)'(BULLET_H);
    active      = slot_q.active;
    active_next = slot_d.active;
    hit         = slot_q.active
                & ({1'b0, pixel_x} >= {1'b0, slot_q.x}) & ({1'b0, pixel_x} < x_end)
                & ({1'b0, pixel_y} >= {1'b0, slot_q.y}) & ({1'b0, pixel_y} < y_end);
  end

endmodule

// File: rtl/bullets_pool.sv
// rtl/bullets_pool.sv - three-slot player bullet pool: fire latch, allocator, renderer (optional BULLETS_COOLDOWN_EN)
module bullets_pool
  import bullets_pkg::*;
#(
  parameter int         BULLET_W     = 4,
  parameter int         BULLET_H     = 8,
  parameter int         SPEED        = 4,
  parameter logic [7:0] BULLET_COLOR = 8'hFC
`ifdef BULLETS_COOLDOWN_EN
  ,
  parameter int         COOLDOWN_FRAMES = 8
`endif
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   fireRequest,
  input  logic [COORD_W-1:0]     fireX,
  input  logic [COORD_W-1:0]     fireY,
  input  logic [COORD_W-1:0]     pixelX,
  input  logic [COORD_W-1:0]     pixelY,
  input  logic [NUM_BULLETS-1:0] collision,
  output logic [NUM_BULLETS-1:0] bulletDrawingRequest,
  output logic [7:0]             bulletRGB,
  output logic                   fireAck,
  output logic [1:0]             activeCount
);

  logic                   pend_q, pend_d;
  logic [COORD_W-1:0]     fire_x_q, fire_x_d;
  logic [COORD_W-1:0]     fire_y_q, fire_y_d;
  logic                   ack_q, ack_d;
  logic [NUM_BULLETS-1:0] drq_q, drq_d;
  logic [7:0]             rgb_q, rgb_d;
  logic [1:0]             count_q, count_d;

  logic [NUM_BULLETS-1:0] slot_active, slot_active_next, slot_hit;
  logic [NUM_BULLETS-1:0] free_slots, spawn_sel, spawn_vec;
  logic [COORD_W-1:0]     spawn_y;
  logic                   fire_y_ok, cooldown_ok, accept;

  // Allocation: a slot must be idle before this frame's move; a slot being
  // hit this cycle is skipped so fireAck never reports a spawn that is lost.
  always_comb begin
    free_slots = ~slot_active & ~collision;
    spawn_sel  = free_slots & (~free_slots + 3'd1);
    fire_y_ok  = fire_y_q >= COORD_W'(BULLET_H);
    accept     = startOfFrame & pend_q & fire_y_ok & (|free_slots) & cooldown_ok;
    spawn_vec  = accept ? spawn_sel : '0;
    spawn_y    = fire_y_q - COORD_W'(BULLET_H);
  end

`ifdef BULLETS_COOLDOWN_EN
  logic [3:0] cooldown_q, cooldown_d;

  // Cooldown counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown_q <= '0;
    end else begin
      cooldown_q <= cooldown_d;
    end
  end

  // Reload on a spawn, otherwise count frames down to zero.
  always_comb begin
    cooldown_ok = (cooldown_q == 4'd0);
    cooldown_d  = cooldown_q;
    if (accept) begin
      cooldown_d = 4'(COOLDOWN_FRAMES);
    end else if (startOfFrame && cooldown_q != 4'd0) begin
      cooldown_d = cooldown_q - 4'd1;
    end
  end
`else
  assign cooldown_ok = 1'b1;
`endif

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H),
      .SPEED    (SPEED)
    ) u_slot (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (startOfFrame),
      .spawn          (spawn_vec[i]),
      .kill           (collision[i]),
      .spawn_x        (fire_x_q),
      .spawn_y        (spawn_y),
      .pixel_x        (pixelX),
      .pixel_y        (pixelY),
      .active         (slot_active[i]),
      .active_next    (slot_active_next[i]),
      .hit            (slot_hit[i])
    );
  end

  // Fire latch: a new request wins over the frame-start clear, so a request
  // arriving with startOfFrame waits for the following frame.
  always_comb begin
    pend_d   = pend_q;
    fire_x_d = fire_x_q;
    fire_y_d = fire_y_q;
    if (fireRequest) begin
      pend_d   = 1'b1;
      fire_x_d = fireX;
      fire_y_d = fireY;
    end else if (startOfFrame) begin
      pend_d = 1'b0;
    end
  end

  // Output register inputs; activeCount tracks slot state on the same edge.
  always_comb begin
    ack_d   = accept;
    drq_d   = slot_hit;
    rgb_d   = (|slot_hit) ? BULLET_COLOR : 8'h00;
    count_d = popcount3(slot_active_next);
  end

  // Fire latch and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_q   <= 1'b0;
      fire_x_q <= '0;
      fire_y_q <= '0;
      ack_q    <= 1'b0;
      drq_q    <= '0;
      rgb_q    <= 8'h00;
      count_q  <= 2'd0;
    end else begin
      pend_q   <= pend_d;
      fire_x_q <= fire_x_d;
      fire_y_q <= fire_y_d;
      ack_q    <= ack_d;
      drq_q    <= drq_d;
      rgb_q    <= rgb_d;
      count_q  <= count_d;
    end
  end

  assign bulletDrawingRequest = drq_q;
  assign bulletRGB            = rgb_q;
  assign fireAck              = ack_q;
  assign activeCount          = count_q;

endmodule

// File: tb/tb_bullets_pool.sv
// tb/tb_bullets_pool.sv - scoreboard bench for bullets_pool with a behavioural pool model
module tb_bullets_pool;

  localparam int W        = 4;
  localparam int H        = 8;
  localparam int SPD      = 4;
  localparam int COLOR    = 8'hFC;
  localparam int COOLDOWN = 8;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, fireRequest;
  logic [10:0] fireX, fireY, pixelX, pixelY;
  logic [2:0]  collision;
  logic [2:0]  bulletDrawingRequest;
  logic [7:0]  bulletRGB;
  logic        fireAck;
  logic [1:0]  activeCount;

  always #5 clk = ~clk;

  bullets_pool dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .fireRequest          (fireRequest),
    .fireX                (fireX),
    .fireY                (fireY),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .collision            (collision),
    .bulletDrawingRequest (bulletDrawingRequest),
    .bulletRGB            (bulletRGB),
    .fireAck              (fireAck),
    .activeCount          (activeCount)
  );

  typedef struct {
    int ack;
    int drq;
    int rgb;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;

  bit m_act[3];
  int m_x[3];
  int m_y[3];
  bit m_pend;
  int m_fx, m_fy, m_cd;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_pend = 0;
    m_fx   = 0;
    m_fy   = 0;
    m_cd   = 0;
  endtask

  // Pool rules applied to one clock: outputs come from the pre-edge pool.
  task automatic model_cycle(input bit sof, input bit fire, input int fx, input int fy,
                             input int px, input int py, input int col);
    exp_t e;
    int   hits = 0;
    int   sel  = -1;
    int   cnt  = 0;
    bit   accept;
    for (int i = 0; i < 3; i++)
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + W && py >= m_y[i] && py < m_y[i] + H)
        hits |= (1 << i);
    for (int i = 0; i < 3; i++)
      if (sel < 0 && !m_act[i] && col[i] == 1'b0) sel = i;
    accept = sof && m_pend && m_fy >= H && sel >= 0 && m_cd == 0;
`ifdef BULLETS_COOLDOWN_EN
    if (sof) begin
      if (accept) m_cd = COOLDOWN;
      else if (m_cd > 0) m_cd = m_cd - 1;
    end
`endif
    for (int i = 0; i < 3; i++) begin
      if (col[i]) m_act[i] = 0;
      else if (sof) begin
        if (accept && i == sel) begin
          m_act[i] = 1;
          m_x[i]   = m_fx;
          m_y[i]   = m_fy - H;
        end else if (m_act[i]) begin
          if (m_y[i] >= SPD) m_y[i] = m_y[i] - SPD;
          else m_act[i] = 0;
        end
      end
    end
    if (fire) begin
      m_pend = 1;
      m_fx   = fx;
      m_fy   = fy;
    end else if (sof) m_pend = 0;
    for (int i = 0; i < 3; i++) cnt += int'(m_act[i]);
    e.ack = int'(accept);
    e.drq = hits;
    e.rgb = (hits != 0) ? COLOR : 0;
    e.cnt = cnt;
    exp_q.push_back(e);
    if (accept) ack_q.push_back(cnt);
  endtask

  // Drive one cycle of inputs, record its expectation, return after the edge.
  task automatic step(input bit sof, input bit fire, input int fx, input int fy,
                      input int px, input int py, input int col);
    @(negedge clk);
    startOfFrame = sof;
    fireRequest  = fire;
    fireX        = 11'(fx);
    fireY        = 11'(fy);
    pixelX       = 11'(px);
    pixelY       = 11'(py);
    collision    = 3'(col);
    model_cycle(sof, fire, fx, fy, px, py, col);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    fireRequest  = 1'b0;
    collision    = 3'b000;
    #1;
    check({tag, "_drq"}, int'(bulletDrawingRequest), 0);
    check({tag, "_rgb"}, int'(bulletRGB), 0);
    check({tag, "_ack"}, int'(fireAck), 0);
    check({tag, "_count"}, int'(activeCount), 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fireAck", int'(fireAck), e.ack);
      check("drawReq", int'(bulletDrawingRequest), e.drq);
      check("rgb", int'(bulletRGB), e.rgb);
      check("activeCount", int'(activeCount), e.cnt);
    end
    if (fireAck) begin
      if (ack_q.size() == 0) check("ack_without_spawn", 1, 0);
      else check("ack_count", int'(activeCount), ack_q.pop_front());
    end
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    fireRequest  = 1'b0;
    fireX        = '0;
    fireY        = '0;
    pixelX       = '0;
    pixelY       = '0;
    collision    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Spawn above the player, then hit test inside and just outside.
    step(0, 1, 100, 200, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("spawn_ack", int'(fireAck), 1);
    check("spawn_count", int'(activeCount), 1);
    step(0, 0, 0, 0, 101, 195, 0);
    check("hit_drq", int'(bulletDrawingRequest), 1);
    check("hit_rgb", int'(bulletRGB), 8'hFC);
    check("ack_one_cycle", int'(fireAck), 0);
    step(0, 0, 0, 0, 104, 195, 0);
    check("miss_drq", int'(bulletDrawingRequest), 0);
    check("miss_rgb", int'(bulletRGB), 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 100, 180, 0);
    check("moved_top_hit", int'(bulletDrawingRequest), 1);
    step(0, 0, 0, 0, 100, 179, 0);
    check("moved_above_miss", int'(bulletDrawingRequest), 0);

    // y=3 leaves the screen instead of wrapping.
    do_reset("reset2");
    step(0, 1, 50, 11, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("low_spawn_count", int'(activeCount), 1);
    step(1, 0, 0, 0, 50, 2047, 0);
    check("offscreen_count", int'(activeCount), 0);

`ifndef BULLETS_COOLDOWN_EN
    // Fill the pool, reject the fourth, free slot1 and refill it.
    do_reset("reset3");
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 10 + 20 * k, 400, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check($sformatf("fill_ack%0d", k), int'(fireAck), (k < 3) ? 1 : 0);
    end
    check("full_count", int'(activeCount), 3);
    step(0, 0, 0, 0, 0, 0, 3'b010);
    check("collide_count", int'(activeCount), 2);
    step(0, 1, 90, 400, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("refill_ack", int'(fireAck), 1);
    step(0, 0, 0, 0, 91, 393, 0);
    check("refill_slot1", int'(bulletDrawingRequest), 3'b010);
    check("refill_count", int'(activeCount), 3);
`else
    // Cooldown: firing every frame only spawns on frames 0 and 9.
    do_reset("reset3");
    for (int f = 0; f < 12; f++) begin
      step(0, 1, 300, 400, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check($sformatf("cooldown_ack%0d", f), int'(fireAck), (f == 0 || f == 9) ? 1 : 0);
    end
`endif
    do_reset("midflight");

    // Too-high fire rejected; fire coinciding with frame start waits a frame.
    step(0, 1, 100, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("low_fire_ack", int'(fireAck), 0);
    check("low_fire_count", int'(activeCount), 0);
    step(1, 1, 100, 200, 0, 0, 0);
    check("same_cycle_ack", int'(fireAck), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("next_frame_ack", int'(fireAck), 1);

    // Right screen edge: x+W exceeds 11 bits but must still hit.
    do_reset("reset4");
    step(0, 1, 2046, 100, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2047, 93, 0);
    check("edge_hit", int'(bulletDrawingRequest), 1);

    // Randomized traffic against the model.
    do_reset("reset5");
    for (int c = 0; c < 3000; c++) begin
      bit sof, fire;
      int fx, fy, px, py, col, k;
      sof  = (c % 17) == 16;
      fire = $urandom_range(0, 5) == 0;
      fx   = $urandom_range(0, 639);
      fy   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 479);
      if ($urandom_range(0, 1) == 1) begin
        k  = $urandom_range(0, 2);
        px = m_x[k] + $urandom_range(0, 6) - 1;
        py = m_y[k] + $urandom_range(0, 10) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px > 2047) px = 2047;
      end else begin
        px = $urandom_range(0, 2047);
        py = $urandom_range(0, 2047);
      end
      col = (!sof && $urandom_range(0, 30) == 0) ? $urandom_range(1, 7) : 0;
      step(sof, fire, fx, fy, px, py, col);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size() + ack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
